tblink_rpc_host_req: RTL and testbench
======================================

# tblink_rpc_host_req

Host-side initiator for the tblink RPC byte-stream link: serializes one request (size, command, id, parameter bytes) onto an 8-bit valid/ready output stream, then parses the matching response frame (dst, size, command 0, id, data bytes) from an 8-bit valid/ready input stream. It sits opposite the device-side command processor and drives its inbound port. User side uses the toggle put/get handshake.

## Interface
- REQ_PARAMS_SZ, 4, max request parameter bytes (>=1)
- RSP_SZ, 4, response data bytes retained (>=1)

- uclock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- tx_dat  out  8  outbound byte (registered)
- tx_valid  out  1  outbound byte valid
- tx_ready  in  1  downstream accepts byte
- rx_dat  in  8  inbound byte
- rx_valid  in  1  inbound byte valid
- rx_ready  out  1  block accepts byte
- req_cmd  in  8  command code, nonzero
- req_sz  in  8  parameter byte count, 0..REQ_PARAMS_SZ
- req_params  in  8*REQ_PARAMS_SZ  parameter bytes, byte 0 at [7:0]
- req_put_i  in  1  toggled by user to issue request
- req_get_i  out  1  toggled when response complete
- rsp_dat  out  8*RSP_SZ  response data, last-received byte at [7:0]
- rsp_sz  out  8  response data byte count received
- rsp_id  out  8  id of completed request
- rsp_err  out  1  response frame malformed/mismatched
- busy  out  1  request or response in flight

## Operation
- Byte transfer on any edge with valid && ready.
- FSM: IDLE, TX_SZ, TX_CMD, TX_ID, TX_PRM, RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT.
- IDLE: when req_put_i != req_get_i, capture req_cmd, req_params, n = min(req_sz, REQ_PARAMS_SZ); load tx_dat = n+1; -> TX_SZ.
- Request frame: SZ (n+1), CMD, ID, then param bytes n-1 down to 0 (byte n-1 first, byte 0 last). n=0: TX_ID -> RX_DST.
- ID: 8-bit counter, 0 after reset, sent value = counter; counter increments on ID byte handshake, wraps 255->0.
- RX_DST: byte consumed, any value accepted. RX_SZ: data count d = SZ-1 (SZ=0 -> d=0, err). RX_CMD: nonzero -> err. RX_ID: != sent id -> err. RX_DAT: d bytes, each shifts rsp shift register left by 8, new byte into [7:0]; bytes beyond RSP_SZ shift out the oldest.
- Errors never abort: frame always consumed per its SZ.
- Completion (handshake of ID byte when d=0, else last data byte): at that edge register rsp_dat, rsp_sz=d, rsp_id, rsp_err; toggle req_get_i; -> IDLE. rsp_dat cleared to 0 at start of each response.
- req_put_i toggles while busy are not lost: serviced on return to IDLE (level compare).

## Timing
- Reset: tx_dat=0, tx_valid=0, rx_ready=0, req_get_i=0, rsp_dat=0, rsp_sz=0, rsp_id=0, rsp_err=0, busy=0, id counter=0, state IDLE. Reset mid-frame aborts with no toggle; partial outputs not updated.
- tx_valid = state in TX_*; rx_ready = state in RX_*; busy = state != IDLE.
- Request captured edge N -> tx_valid=1 from N+1; with tx_ready held high, request occupies 3+n consecutive cycles.
- Last tx handshake edge -> rx_ready=1 next cycle; no rx bytes accepted outside RX_*.
- tx_dat holds stable while tx_valid && !tx_ready.
- Completion edge -> IDLE; pending toggle captured earliest next edge (one idle cycle between requests).
- Outputs rsp_* stable from completion until next completion.

## Test plan
- REQ_PARAMS_SZ=4: cmd=0x05, sz=2, params=0x0000AABB, tx_ready=1 -> tx 0x03,0x05,0x00,0xAA,0xBB; response 0x00,0x02,0x00,0x00,0x7E -> rsp_dat=0x0000007E, rsp_sz=1, rsp_id=0, rsp_err=0, req_get_i=1.
- cmd=0x09, sz=0 -> tx 0x01,0x09,0x01; response 0x00,0x01,0x00,0x01 -> rsp_sz=0, rsp_dat=0, rsp_id=1, rsp_err=0.
- Response with id 0x33 vs sent 0x02, SZ=3, data 0x11,0x22 -> all 6 bytes consumed, rsp_err=1, rsp_dat=0x00001122, toggle occurs.
- tx_ready toggling 1/0 each cycle and rx_valid gaps -> identical byte sequence/results as first test; tx_dat never changes while stalled.
- RSP_SZ=4, response SZ=7, data 0x01..0x06 -> rsp_dat=0x03040506, rsp_sz=6.
- 256 back-to-back requests -> ids 0..255 then 0; reset asserted during RX_DAT -> all outputs 0, no req_get_i toggle, next request uses id 0.

Source files
------------

// File: rtl/tblink_rpc_host_req.sv
// rtl/tblink_rpc_host_req.sv - host-side tblink RPC request serializer and response parser
//
// Issues one request frame (SZ, CMD, ID, params n-1..0) on the tx byte stream,
// then consumes the matching response frame (DST, SZ, CMD, ID, data) from the
// rx byte stream and reports it on the rsp_* outputs.
//
// Ports:
//   uclock, reset          clock, asynchronous active-high reset
//   tx_dat/valid/ready     outbound request bytes (tx_dat registered)
//   rx_dat/valid/ready     inbound response bytes
//   req_cmd/sz/params      request contents, sampled when a request is taken
//   req_put_i / req_get_i  toggle handshake: put != get means a request is pending
//   rsp_dat/sz/id/err      last completed response (data newest byte at [7:0])
//   busy                   a request or its response is in flight
module tblink_rpc_host_req #(
    parameter int REQ_PARAMS_SZ = 4,
    parameter int RSP_SZ        = 4
) (
    input  logic                       uclock,
    input  logic                       reset,
    output logic [7:0]                 tx_dat,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic [7:0]                 rx_dat,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    input  logic [7:0]                 req_cmd,
    input  logic [7:0]                 req_sz,
    input  logic [8*REQ_PARAMS_SZ-1:0] req_params,
    input  logic                       req_put_i,
    output logic                       req_get_i,
    output logic [8*RSP_SZ-1:0]        rsp_dat,
    output logic [7:0]                 rsp_sz,
    output logic [7:0]                 rsp_id,
    output logic                       rsp_err,
    output logic                       busy
);

    typedef enum logic [3:0] {
        IDLE, TX_SZ, TX_CMD, TX_ID, TX_PRM,
        RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT
    } state_t;

    localparam logic [7:0] MAX_N = 8'(REQ_PARAMS_SZ);

    state_t state, state_nxt;

    logic [7:0]                 cmd_q;
    logic [7:0]                 n_q;
    logic [7:0]                 idx_q;      // param bytes still to send after the current one
    logic [8*REQ_PARAMS_SZ-1:0] prm_q;      // params left-aligned: next byte to send is on top
    logic [7:0]                 id_cnt;
    logic [7:0]                 sent_id;
    logic [7:0]                 d_q;        // response data byte count
    logic [7:0]                 cnt_q;      // response data bytes still expected
    logic [8*RSP_SZ-1:0]        shreg;
    logic                       err_acc;

    logic                       tx_hs;
    logic                       rx_hs;
    logic                       req_pend;
    logic [7:0]                 n_sel;
    logic [7:0]                 sz_d;
    logic [7:0]                 prm_shift;
    logic                       id_bad;
    logic [8*RSP_SZ-1:0]        shreg_nxt;

    assign tx_valid = state inside {TX_SZ, TX_CMD, TX_ID, TX_PRM};
    assign rx_ready = state inside {RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT};
    assign busy     = (state != IDLE);

    assign tx_hs     = tx_valid && tx_ready;
    assign rx_hs     = rx_valid && rx_ready;
    assign req_pend  = req_put_i ^ req_get_i;
    assign n_sel     = (req_sz > MAX_N) ? MAX_N : req_sz;
    assign prm_shift = MAX_N - n_sel;
    assign sz_d      = (rx_dat == 8'd0) ? 8'd0 : rx_dat - 8'd1;
    assign id_bad    = (rx_dat != sent_id);

    // Response shift register: oldest byte falls off the top once RSP_SZ is exceeded.
    generate
        if (RSP_SZ == 1) begin : g_shift_one
            assign shreg_nxt = rx_dat;
        end else begin : g_shift_many
            assign shreg_nxt = {shreg[8*RSP_SZ-9:0], rx_dat};
        end
    endgenerate

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (req_pend) state_nxt = TX_SZ;
            TX_SZ:  if (tx_hs) state_nxt = TX_CMD;
            TX_CMD: if (tx_hs) state_nxt = TX_ID;
            TX_ID:  if (tx_hs) state_nxt = (n_q == 8'd0) ? RX_DST : TX_PRM;
            TX_PRM: if (tx_hs && idx_q == 8'd0) state_nxt = RX_DST;
            RX_DST: if (rx_hs) state_nxt = RX_SZ;
            RX_SZ:  if (rx_hs) state_nxt = RX_CMD;
            RX_CMD: if (rx_hs) state_nxt = RX_ID;
            RX_ID:  if (rx_hs) state_nxt = (d_q == 8'd0) ? IDLE : RX_DAT;
            RX_DAT: if (rx_hs && cnt_q == 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            tx_dat    <= 8'd0;
            cmd_q     <= 8'd0;
            n_q       <= 8'd0;
            idx_q     <= 8'd0;
            prm_q     <= '0;
            id_cnt    <= 8'd0;
            sent_id   <= 8'd0;
            d_q       <= 8'd0;
            cnt_q     <= 8'd0;
            shreg     <= '0;
            err_acc   <= 1'b0;
            req_get_i <= 1'b0;
            rsp_dat   <= '0;
            rsp_sz    <= 8'd0;
            rsp_id    <= 8'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_pend) begin
                        cmd_q  <= req_cmd;
                        n_q    <= n_sel;
                        prm_q  <= req_params << {prm_shift, 3'b000};
                        tx_dat <= n_sel + 8'd1;
                    end
                end
                TX_SZ: if (tx_hs) tx_dat <= cmd_q;
                TX_CMD: if (tx_hs) tx_dat <= id_cnt;
                TX_ID: begin
                    if (tx_hs) begin
                        sent_id <= id_cnt;
                        id_cnt  <= id_cnt + 8'd1;
                        if (n_q != 8'd0) begin
                            idx_q  <= n_q - 8'd1;
                            tx_dat <= prm_q[8*REQ_PARAMS_SZ-1 -: 8];
                            prm_q  <= prm_q << 8;
                        end
                    end
                end
                TX_PRM: begin
                    if (tx_hs && idx_q != 8'd0) begin
                        idx_q  <= idx_q - 8'd1;
                        tx_dat <= prm_q[8*REQ_PARAMS_SZ-1 -: 8];
                        prm_q  <= prm_q << 8;
                    end
                end
                RX_DST: if (rx_hs) shreg <= '0;
                RX_SZ: begin
                    if (rx_hs) begin
                        d_q     <= sz_d;
                        err_acc <= (rx_dat == 8'd0);
                    end
                end
                RX_CMD: if (rx_hs && rx_dat != 8'd0) err_acc <= 1'b1;
                RX_ID: begin
                    if (rx_hs) begin
                        cnt_q <= d_q;
                        if (id_bad) err_acc <= 1'b1;
                        if (d_q == 8'd0) begin
                            rsp_dat   <= shreg;
                            rsp_sz    <= 8'd0;
                            rsp_id    <= sent_id;
                            rsp_err   <= err_acc | id_bad;
                            req_get_i <= ~req_get_i;
                        end
                    end
                end
                RX_DAT: begin
                    if (rx_hs) begin
                        shreg <= shreg_nxt;
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            rsp_dat   <= shreg_nxt;
                            rsp_sz    <= d_q;
                            rsp_id    <= sent_id;
                            rsp_err   <= err_acc;
                            req_get_i <= ~req_get_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tblink_rpc_host_req.sv
// tb/tb_tblink_rpc_host_req.sv - scoreboard bench for tblink_rpc_host_req
module tb_tblink_rpc_host_req;

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  sz;
        logic [7:0]  id;
        logic        err;
    } res_t;

    logic        uclock;
    logic        reset;
    logic [7:0]  tx_dat;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_dat;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  req_cmd;
    logic [7:0]  req_sz;
    logic [31:0] req_params;
    logic        req_put_i;
    logic        req_get_i;
    logic [31:0] rsp_dat;
    logic [7:0]  rsp_sz;
    logic [7:0]  rsp_id;
    logic        rsp_err;
    logic        busy;

    int          n_cmp;
    int          n_bad;
    logic [7:0]  exp_id;
    logic [7:0]  exp_tx[$];
    res_t        exp_res[$];
    logic [7:0]  rsp_q[$];

    tblink_rpc_host_req #(.REQ_PARAMS_SZ(4), .RSP_SZ(4)) dut (
        .uclock     (uclock),
        .reset      (reset),
        .tx_dat     (tx_dat),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_dat     (rx_dat),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .req_cmd    (req_cmd),
        .req_sz     (req_sz),
        .req_params (req_params),
        .req_put_i  (req_put_i),
        .req_get_i  (req_get_i),
        .rsp_dat    (rsp_dat),
        .rsp_sz     (rsp_sz),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial uclock = 1'b0;
    always #5 uclock = ~uclock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected response fields derived from the response bytes queued in rsp_q.
    function automatic res_t model(input logic [7:0] id);
        res_t r;
        int   d;
        d     = (rsp_q[1] == 8'd0) ? 0 : int'(rsp_q[1]) - 1;
        r.err = (rsp_q[1] == 8'd0) || (rsp_q[2] != 8'd0) || (rsp_q[3] != id);
        r.dat = 32'd0;
        for (int k = 0; k < d; k++) r.dat = {r.dat[23:0], rsp_q[4+k]};
        r.sz  = 8'(d);
        r.id  = id;
        return r;
    endfunction

    task automatic run_req(input logic [7:0] cmd, input logic [7:0] sz, input logic [31:0] prm,
                           input bit do_toggle, input bit stall, input bit gap,
                           input bit pre_next, input int abort_n);
        int         n;
        int         consumed;
        bit         done;
        bit         aborted;
        bit         prev_stall;
        logic [7:0] held;
        logic       old_get;
        res_t       r;
        n = (sz > 8'd4) ? 4 : int'(sz);
        req_cmd    = cmd;
        req_sz     = sz;
        req_params = prm;
        if (do_toggle) req_put_i = ~req_put_i;
        exp_tx.push_back(8'(n + 1));
        exp_tx.push_back(cmd);
        exp_tx.push_back(exp_id);
        for (int k = n - 1; k >= 0; k--) exp_tx.push_back(prm[8*k +: 8]);
        exp_res.push_back(model(exp_id));
        exp_id     = exp_id + 8'd1;
        old_get    = req_get_i;
        consumed   = 0;
        done       = 0;
        aborted    = 0;
        prev_stall = 0;
        held       = 8'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge uclock);
            if (cyc == 0) chk("tx_start", tx_valid, 1);
            if (req_get_i != old_get) begin done = 1; break; end
            if (abort_n > 0 && consumed == abort_n) begin aborted = 1; break; end
            if (pre_next && cyc == 2) req_put_i = ~req_put_i;
            tx_ready = stall ? (cyc % 2 == 1) : 1'b1;
            if (consumed < rsp_q.size() && !(gap && (cyc % 3 == 1))) begin
                rx_valid = 1'b1;
                rx_dat   = rsp_q[consumed];
            end else begin
                rx_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_dat", tx_dat, held);
            end
            if (tx_valid && tx_ready) begin
                chk("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) chk("tx_byte", tx_dat, exp_tx.pop_front());
            end
            prev_stall = tx_valid && !tx_ready;
            held       = tx_dat;
            if (rx_valid && rx_ready) consumed++;
        end
        rx_valid = 1'b0;
        if (aborted) begin
            r = exp_res.pop_back();
            chk("abort_tx_drained", exp_tx.size(), 0);
        end else begin
            chk("done", done, 1);
            if (done) begin
                r = exp_res.pop_front();
                chk("rsp_dat", rsp_dat, r.dat);
                chk("rsp_sz", rsp_sz, r.sz);
                chk("rsp_id", rsp_id, r.id);
                chk("rsp_err", rsp_err, r.err);
                chk("rx_consumed", consumed, rsp_q.size());
                chk("tx_drained", exp_tx.size(), 0);
                chk("idle_after_done", busy, 0);
            end else begin
                exp_tx.delete();
                exp_res.delete();
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        exp_id     = 8'd0;
        reset      = 1'b1;
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        rx_dat     = 8'd0;
        req_cmd    = 8'd0;
        req_sz     = 8'd0;
        req_params = 32'd0;
        req_put_i  = 1'b0;
        repeat (2) @(negedge uclock);
        #1;
        chk("reset_outputs", {tx_dat, tx_valid, rx_ready, req_get_i, rsp_dat, rsp_sz, rsp_id, rsp_err, busy}, 0);
        @(negedge uclock);
        reset = 1'b0;
        #1;

        // basic request with two params
        rsp_q = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h7E};
        run_req(8'h05, 8'd2, 32'h0000AABB, 1, 0, 0, 0, 0);
        chk("t1_get", req_get_i, 1);
        chk("t1_dat", rsp_dat, 32'h0000007E);

        // zero params, zero data
        rsp_q = '{8'h00, 8'h01, 8'h00, 8'h01};
        run_req(8'h09, 8'd0, 32'h0, 1, 0, 0, 0, 0);
        chk("t2_id", rsp_id, 1);
        chk("t2_sz", rsp_sz, 0);

        // wrong id in response
        rsp_q = '{8'h00, 8'h03, 8'h00, 8'h33, 8'h11, 8'h22};
        run_req(8'h21, 8'd1, 32'h00000044, 1, 0, 0, 0, 0);
        chk("t3_err", rsp_err, 1);
        chk("t3_dat", rsp_dat, 32'h00001122);

        // back-pressure on tx and gaps on rx
        rsp_q = '{8'h00, 8'h02, 8'h00, 8'h03, 8'h7E};
        run_req(8'h05, 8'd2, 32'h0000AABB, 1, 1, 1, 0, 0);

        // data longer than RSP_SZ
        rsp_q = '{8'h00, 8'h07, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_req(8'h03, 8'd4, 32'h01020304, 1, 0, 0, 0, 0);
        chk("t5_dat", rsp_dat, 32'h03040506);
        chk("t5_sz", rsp_sz, 6);

        // reset while in RX_DAT
        rsp_q = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hAA, 8'hBB};
        run_req(8'h07, 8'd1, 32'h00000055, 1, 0, 0, 0, 5);
        reset     = 1'b1;
        req_put_i = 1'b0;
        #1;
        chk("midreset_outputs", {tx_dat, tx_valid, rx_ready, req_get_i, rsp_dat, rsp_sz, rsp_id, rsp_err, busy}, 0);
        @(negedge uclock);
        reset  = 1'b0;
        exp_id = 8'd0;
        repeat (3) @(negedge uclock);
        #1;
        chk("post_reset_idle", busy, 0);
        chk("post_reset_get", req_get_i, 0);

        // 257 requests: ids wrap 255 -> 0, with pre-issued toggles while busy
        for (int i = 0; i < 257; i++) begin
            int d;
            d = $urandom_range(0, 5);
            rsp_q = {};
            rsp_q.push_back(8'h00);
            rsp_q.push_back(8'(d + 1));
            rsp_q.push_back(8'h00);
            rsp_q.push_back(exp_id);
            for (int k = 0; k < d; k++) rsp_q.push_back(8'($urandom));
            run_req(8'($urandom_range(1, 255)), 8'(i % 6), $urandom,
                    !(i > 0 && ((i - 1) % 2 == 1)), (i % 4 == 1), (i % 4 == 2),
                    (i % 2 == 1) && (i < 256), 0);
        end
        chk("wrap_id", rsp_id, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
